// File: rtl/datapath.sv
// datapath: 16 x 8-bit register file with two combinational read ports and an
// 8-bit ALU whose result can be written back into the register file.
// Optional feature macro: DATAPATH_FLAG_REG_EN
//   undefined -> alu_zero / alu_carry are combinational flags of the current
//                operands and opcode
//   defined   -> alu_zero / alu_carry are registers that load the ALU flags
//                only on ALU write-back edges and hold otherwise
module datapath (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alu_en,
    input  logic [2:0] alu_opcode,
    input  logic [7:0] user_write_data,
    input  logic [3:0] write_addr,
    input  logic [3:0] ra_addr,
    input  logic [3:0] rb_addr,
    input  logic       write_en,
    output logic [7:0] read_a,
    output logic [7:0] read_b,
    output logic       alu_zero,
    output logic       alu_carry
);

    localparam int DATA_W = 8;
    localparam int NREGS  = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic              carry;
        logic [DATA_W-1:0] result;
    } alu_out_t;

    // Full ALU evaluation: result plus carry / borrow / shifted-out bit.
    // ADD and SUB use a 9-bit intermediate; for SUB bit 8 of the wrapped
    // difference is set exactly when A < B, which is the borrow.
    function automatic alu_out_t alu_eval(input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b,
                                          input logic [2:0]        op);
        alu_out_t        o;
        logic [DATA_W:0] wide;
        o    = '0;
        wide = '0;
        case (alu_op_e'(op))
            OP_ADD: begin
                wide     = {1'b0, a} + {1'b0, b};
                o.result = wide[DATA_W-1:0];
                o.carry  = wide[DATA_W];
            end
            OP_SUB: begin
                wide     = {1'b0, a} - {1'b0, b};
                o.result = wide[DATA_W-1:0];
                o.carry  = wide[DATA_W];
            end
            OP_AND: o.result = a & b;
            OP_OR:  o.result = a | b;
            OP_XOR: o.result = a ^ b;
            OP_NOT: o.result = ~a;
            OP_SHL: begin
                o.result = {a[DATA_W-2:0], 1'b0};
                o.carry  = a[DATA_W-1];
            end
            OP_SHR: begin
                o.result = {1'b0, a[DATA_W-1:1]};
                o.carry  = a[0];
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Zero detect on an ALU result.
    function automatic logic is_zero(input logic [DATA_W-1:0] v);
        return (v == '0);
    endfunction

    logic [DATA_W-1:0] regs [NREGS];
    alu_out_t          alu_out;
    logic              alu_zero_c;
    logic [DATA_W-1:0] wdata;

    // Combinational read ports; both ports index the same storage, so equal
    // addresses always return equal data.
    assign read_a = regs[ra_addr];
    assign read_b = regs[rb_addr];

    // ALU operates on the pre-edge register contents, which makes a write to
    // one of its own operand registers a clean read-modify-write.
    always_comb begin
        alu_out    = alu_eval(read_a, read_b, alu_opcode);
        alu_zero_c = is_zero(alu_out.result);
    end

    // Write-back source select.
    always_comb begin
        wdata = alu_en ? alu_out.result : user_write_data;
    end

    // Register file: async clear of every entry, single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[write_addr] <= wdata;
        end
    end

`ifdef DATAPATH_FLAG_REG_EN
    logic zero_q;
    logic carry_q;

    // Flags capture only on ALU write-back edges and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (write_en && alu_en) begin
            zero_q  <= alu_zero_c;
            carry_q <= alu_out.carry;
        end
    end

    assign alu_zero  = zero_q;
    assign alu_carry = carry_q;
`else
    assign alu_zero  = alu_zero_c;
    assign alu_carry = alu_out.carry;
`endif

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed stimulus for datapath with a behavioural register-file
// model, a per-cycle compare process and hand-computed literal pins.
`timescale 1ns/1ps
module tb_datapath;

`ifdef DATAPATH_FLAG_REG_EN
    localparam bit FM = 1'b1;
`else
    localparam bit FM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       alu_en = 1'b0;
    logic [2:0] alu_opcode = 3'd0;
    logic [7:0] user_write_data = 8'd0;
    logic [3:0] write_addr = 4'd0;
    logic [3:0] ra_addr = 4'd0;
    logic [3:0] rb_addr = 4'd0;
    logic       write_en = 1'b0;
    logic [7:0] read_a;
    logic [7:0] read_b;
    logic       alu_zero;
    logic       alu_carry;

    datapath dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alu_en          (alu_en),
        .alu_opcode      (alu_opcode),
        .user_write_data (user_write_data),
        .write_addr      (write_addr),
        .ra_addr         (ra_addr),
        .rb_addr         (rb_addr),
        .write_en        (write_en),
        .read_a          (read_a),
        .read_b          (read_b),
        .alu_zero        (alu_zero),
        .alu_carry       (alu_carry)
    );

    always #5 clk = ~clk;

    int   mdl [16];
    int   mdl_z = 0;
    int   mdl_c = 0;
    int   checks = 0;
    int   errors = 0;
    logic chk_on = 1'b0;
    logic pin_ab = 1'b0;
    logic pin_f  = 1'b0;
    int   pin_a, pin_b, pin_z, pin_c;

    // opcode sweep expectations for A = B = 8'h80, in opcode order
    int sw_res [8] = '{'h00, 'h00, 'h80, 'h80, 'h00, 'h7F, 'h00, 'h40};
    int sw_c   [8] = '{1, 0, 0, 0, 0, 0, 1, 0};
    int sw_z   [8] = '{1, 1, 0, 0, 1, 0, 1, 0};

    // ALU behaviour stated as plain integer arithmetic
    function automatic void model_alu(input int a, input int b, input int op,
                                      output int res, output int cy);
        res = 0;
        cy  = 0;
        case (op)
            0: begin res = (a + b) % 256; cy = ((a + b) > 255) ? 1 : 0; end
            1: begin res = (a - b + 256) % 256; cy = (a < b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = 255 - a;
            6: begin res = (a * 2) % 256; cy = (a >= 128) ? 1 : 0; end
            default: begin res = a / 2; cy = a % 2; end
        endcase
    endfunction

    // reference register file and flag registers
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mdl[i] <= 0;
            mdl_z <= 0;
            mdl_c <= 0;
        end else if (write_en) begin : upd
            int r, c;
            model_alu(mdl[ra_addr], mdl[rb_addr], int'(alu_opcode), r, c);
            if (alu_en) begin
                mdl[write_addr] <= r;
                mdl_z <= (r == 0) ? 1 : 0;
                mdl_c <= c;
            end else begin
                mdl[write_addr] <= int'(user_write_data);
            end
        end
    end

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    // compare DUT against model (and literal pins) every falling edge
    always @(negedge clk) begin
        if (chk_on) begin : cmp
            int r, c, ez, ec;
            model_alu(mdl[ra_addr], mdl[rb_addr], int'(alu_opcode), r, c);
            if (FM) begin
                ez = mdl_z;
                ec = mdl_c;
            end else begin
                ez = (r == 0) ? 1 : 0;
                ec = c;
            end
            check("read_a", int'(read_a), mdl[ra_addr]);
            check("read_b", int'(read_b), mdl[rb_addr]);
            check("alu_zero", int'(alu_zero), ez);
            check("alu_carry", int'(alu_carry), ec);
            if (pin_ab) begin
                check("pin_read_a", int'(read_a), pin_a);
                check("pin_read_b", int'(read_b), pin_b);
            end
            if (pin_f) begin
                check("pin_zero", int'(alu_zero), pin_z);
                check("pin_carry", int'(alu_carry), pin_c);
            end
        end
    end

    task automatic setin(input logic we, input logic ae, input logic [2:0] op,
                         input logic [7:0] ud, input logic [3:0] wa,
                         input logic [3:0] ra, input logic [3:0] rb);
        write_en        = we;
        alu_en          = ae;
        alu_opcode      = op;
        user_write_data = ud;
        write_addr      = wa;
        ra_addr         = ra;
        rb_addr         = rb;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pin_rd(input int a, input int b);
        pin_a  = a;
        pin_b  = b;
        pin_ab = 1'b1;
        @(negedge clk);
        #1;
        pin_ab = 1'b0;
    endtask

    task automatic pin_fl(input int z, input int c);
        pin_z = z;
        pin_c = c;
        pin_f = 1'b1;
        @(negedge clk);
        #1;
        pin_f = 1'b0;
    endtask

    task automatic pin_all(input int a, input int b, input int z, input int c);
        pin_a  = a;
        pin_b  = b;
        pin_z  = z;
        pin_c  = c;
        pin_ab = 1'b1;
        pin_f  = 1'b1;
        @(negedge clk);
        #1;
        pin_ab = 1'b0;
        pin_f  = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_on = 1'b1;

        // reset held, write attempted: everything stays zero
        setin(1'b1, 1'b0, 3'd0, 8'h5A, 4'd2, 4'd2, 4'd2);
        pin_all(0, 0, FM ? 0 : 1, 0);
        tick();
        pin_rd(0, 0);
        rst_n = 1'b1;
        tick();
        // first edge after release performs the write
        pin_rd('h5A, 'h5A);
        tick();

        // fill reg i with i*8'h11
        for (int i = 0; i < 16; i++) begin
            setin(1'b1, 1'b0, 3'd0, 8'(i * 17), 4'(i), 4'd0, 4'd0);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            setin(1'b0, 1'b0, 3'd0, 8'h00, 4'd0, 4'(i), 4'(15 - i));
            pin_rd(i * 17, (15 - i) * 17);
            tick();
        end

        // overwrite reg3, then disabled writes leave reg5 alone
        setin(1'b1, 1'b0, 3'd0, 8'hAA, 4'd3, 4'd3, 4'd5);
        tick();
        setin(1'b0, 1'b0, 3'd0, 8'h11, 4'd5, 4'd3, 4'd5);
        tick();
        setin(1'b0, 1'b1, 3'd4, 8'h11, 4'd5, 4'd3, 4'd5);
        tick();
        pin_rd('hAA, 'h55);
        tick();

        // accumulate loop reg1 += reg0 for 64 cycles
        setin(1'b1, 1'b0, 3'd0, 8'h01, 4'd0, 4'd0, 4'd1);
        tick();
        setin(1'b1, 1'b0, 3'd0, 8'h00, 4'd1, 4'd0, 4'd1);
        tick();
        setin(1'b1, 1'b1, 3'd0, 8'h00, 4'd1, 4'd0, 4'd1);
        repeat (64) tick();
        setin(1'b0, 1'b1, 3'd0, 8'h00, 4'd1, 4'd0, 4'd1);
        pin_all(1, 'h40, 0, 0);
        tick();

        // wrap 0xFF -> 0x00 with carry
        setin(1'b1, 1'b0, 3'd0, 8'hFF, 4'd1, 4'd0, 4'd1);
        tick();
        setin(1'b1, 1'b1, 3'd0, 8'h00, 4'd1, 4'd0, 4'd1);
        pin_all(1, 'hFF, FM ? 0 : 1, FM ? 0 : 1);
        tick();
        setin(1'b0, 1'b0, 3'd0, 8'h00, 4'd1, 4'd0, 4'd1);
        pin_all(1, 0, FM ? 1 : 0, FM ? 1 : 0);
        tick();

        // opcode sweep with A = B = 8'h80, result written to reg4
        setin(1'b1, 1'b0, 3'd0, 8'h80, 4'd2, 4'd0, 4'd0);
        tick();
        setin(1'b1, 1'b0, 3'd0, 8'h80, 4'd3, 4'd0, 4'd0);
        tick();
        for (int k = 0; k < 8; k++) begin
            setin(1'b1, 1'b1, 3'(k), 8'h00, 4'd4, 4'd2, 4'd3);
            if (!FM) pin_fl(sw_z[k], sw_c[k]);
            tick();
            setin(1'b0, 1'b0, 3'd0, 8'h00, 4'd0, 4'd4, 4'd2);
            if (FM) pin_all(sw_res[k], 'h80, sw_z[k], sw_c[k]);
            else    pin_rd(sw_res[k], 'h80);
            tick();
        end

        // reset asserted between edges while a write is pending
        setin(1'b1, 1'b0, 3'd0, 8'h77, 4'd9, 4'd9, 4'd3);
        #1 rst_n = 1'b0;
        pin_all(0, 0, FM ? 0 : 1, 0);
        tick();
        pin_rd(0, 0);
        rst_n = 1'b1;
        tick();
        pin_rd('h77, 0);
        tick();

        // FF + 01 ALU write, then flags observed while operands change
        setin(1'b1, 1'b0, 3'd0, 8'hFF, 4'd6, 4'd0, 4'd0);
        tick();
        setin(1'b1, 1'b0, 3'd0, 8'h01, 4'd7, 4'd0, 4'd0);
        tick();
        setin(1'b1, 1'b1, 3'd0, 8'h00, 4'd8, 4'd6, 4'd7);
        if (!FM) pin_fl(1, 1);
        tick();
        setin(1'b0, 1'b1, 3'd0, 8'h00, 4'd8, 4'd8, 4'd7);
        pin_all(0, 1, FM ? 1 : 0, FM ? 1 : 0);
        tick();
        setin(1'b0, 1'b1, 3'd3, 8'h00, 4'd0, 4'd6, 4'd7);
        pin_all('hFF, 1, FM ? 1 : 0, FM ? 1 : 0);
        tick();

        @(negedge clk);
        #1;
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
